card_deal_scheduler: RTL and testbench

Sequences and shares the single card deck source between the player and dealer hand logic. Runs the opening deal, then arbitrates hit requests round-robin. For each card it issues a one-cycle draw to the deck, registers the returned card and delivers it with a destination tag and per-hand card counts. It sits between the game-flow FSM (start_round) and the deck.

---
 rtl/card_deal_scheduler.sv | 149 ++++++++++++++
 tb/tb_card_deal_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_deal_scheduler.sv
// Deals the opening hand alternately player/dealer, then serves player/dealer hit requests round-robin.
// Optional shoe limit is compiled in with `define CARD_LIMIT_EN.
module card_deal_scheduler #(
  parameter int INIT_CARDS = 4,
  parameter int CARD_LIMIT = 52,
  parameter int DATA_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_round,
  input  logic              player_req,
  input  logic              dealer_req,
  output logic              deck_req,
  input  logic [DATA_W-1:0] deck_card,
  output logic [DATA_W-1:0] card_out,
  output logic              card_valid,
  output logic              card_to_dealer,
  output logic              player_ack,
  output logic              dealer_ack,
  output logic              busy,
  output logic              init_done,
  output logic [3:0]        player_count,
  output logic [3:0]        dealer_count,
  output logic              shoe_empty
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_INIT_DRAW    = 3'd1;
  localparam logic [2:0] S_INIT_DELIVER = 3'd2;
  localparam logic [2:0] S_READY        = 3'd3;
  localparam logic [2:0] S_HIT_DRAW     = 3'd4;
  localparam logic [2:0] S_HIT_DELIVER  = 3'd5;

  if (INIT_CARDS < 2 || INIT_CARDS > 14 || (INIT_CARDS % 2) != 0 ||
      CARD_LIMIT < 1 || DATA_W < 4) begin : g_bad_param
    $error("card_deal_scheduler: illegal parameter combination");
  end

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic is_legal_card(input logic [DATA_W-1:0] c);
    return (c != '0) && (c <= DATA_W'(10));
  endfunction

  logic [2:0] state;
  logic       ptr_dealer;
  logic       grant_dealer;
  logic [3:0] init_idx;
  logic       in_draw;
  logic       in_deliver;
  logic       strobe_ok;
  logic       card_legal;

  assign in_draw    = (state == S_INIT_DRAW) || (state == S_HIT_DRAW);
  assign in_deliver = (state == S_INIT_DELIVER) || (state == S_HIT_DELIVER);
  // A restart in the delivery cycle abandons the card, so strobes are masked combinationally.
  assign strobe_ok  = !reset && !start_round;
  assign card_legal = is_legal_card(deck_card);

  assign deck_req   = in_draw && !shoe_empty;
  assign card_valid = in_deliver && strobe_ok;
  assign player_ack = (state == S_HIT_DELIVER) && !grant_dealer && strobe_ok;
  assign dealer_ack = (state == S_HIT_DELIVER) &&  grant_dealer && strobe_ok;
  assign busy       = (state != S_IDLE) && (state != S_READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      ptr_dealer     <= 1'b0;
      grant_dealer   <= 1'b0;
      init_idx       <= 4'd0;
      card_out       <= '0;
      card_to_dealer <= 1'b0;
      init_done      <= 1'b0;
      player_count   <= 4'd0;
      dealer_count   <= 4'd0;
    end else if (start_round) begin
      state        <= S_INIT_DRAW;
      init_idx     <= 4'd0;
      init_done    <= 1'b0;
      player_count <= 4'd0;
      dealer_count <= 4'd0;
    end else begin
      case (state)
        S_INIT_DRAW: begin
          if (!shoe_empty && card_legal) begin
            card_out       <= deck_card;
            card_to_dealer <= init_idx[0];
            state          <= S_INIT_DELIVER;
          end
        end
        S_INIT_DELIVER: begin
          if (card_to_dealer) dealer_count <= sat_inc(dealer_count);
          else                player_count <= sat_inc(player_count);
          init_idx <= init_idx + 4'd1;
          if (init_idx == 4'(INIT_CARDS - 1)) begin
            state     <= S_READY;
            init_done <= 1'b1;
          end else begin
            state <= S_INIT_DRAW;
          end
        end
        S_READY: begin
          // Contention goes to the pointer; a lone requester wins regardless of it.
          if (player_req || dealer_req) begin
            grant_dealer <= dealer_req && (!player_req || ptr_dealer);
            state        <= S_HIT_DRAW;
          end
        end
        S_HIT_DRAW: begin
          if (!shoe_empty && card_legal) begin
            card_out       <= deck_card;
            card_to_dealer <= grant_dealer;
            state          <= S_HIT_DELIVER;
          end
        end
        S_HIT_DELIVER: begin
          if (grant_dealer) dealer_count <= sat_inc(dealer_count);
          else              player_count <= sat_inc(player_count);
          ptr_dealer <= !grant_dealer;
          state      <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CARD_LIMIT_EN
  localparam int SHOE_W = $clog2(CARD_LIMIT + 1);

  logic [SHOE_W-1:0] shoe_cnt;

  // Shoe usage spans rounds; only reset returns the cards.
  always_ff @(posedge clk) begin
    if (reset) begin
      shoe_cnt <= '0;
    end else if (card_valid && !shoe_empty) begin
      shoe_cnt <= shoe_cnt + SHOE_W'(1);
    end
  end

  assign shoe_empty = (shoe_cnt >= SHOE_W'(CARD_LIMIT));
`else
  assign shoe_empty = 1'b0;
`endif

endmodule

// File: tb/tb_card_deal_scheduler.sv
// Directed bench for card_deal_scheduler: vector table for the opening deal, hits and redraws,
// plus hand-written sequences for restart, saturation and (with CARD_LIMIT_EN) the shoe limit.
module tb_card_deal_scheduler;

`ifdef CARD_LIMIT_EN
  localparam int LIMIT = 6;
`else
  localparam int LIMIT = 52;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_round = 1'b0;
  logic       player_req = 1'b0;
  logic       dealer_req = 1'b0;
  logic       deck_req;
  logic [3:0] deck_card = 4'd0;
  logic [3:0] card_out;
  logic       card_valid;
  logic       card_to_dealer;
  logic       player_ack;
  logic       dealer_ack;
  logic       busy;
  logic       init_done;
  logic [3:0] player_count;
  logic [3:0] dealer_count;
  logic       shoe_empty;

  int errors = 0;
  int checks = 0;

  card_deal_scheduler #(.INIT_CARDS(4), .CARD_LIMIT(LIMIT), .DATA_W(4)) dut (
    .clk(clk), .reset(reset), .start_round(start_round),
    .player_req(player_req), .dealer_req(dealer_req),
    .deck_req(deck_req), .deck_card(deck_card),
    .card_out(card_out), .card_valid(card_valid), .card_to_dealer(card_to_dealer),
    .player_ack(player_ack), .dealer_ack(dealer_ack), .busy(busy),
    .init_done(init_done), .player_count(player_count), .dealer_count(dealer_count),
    .shoe_empty(shoe_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sr, pr, dr;
    logic [3:0] dk;
    logic       e_dreq, e_cv;
    logic [3:0] e_card;
    logic       e_td, e_pa, e_da, e_busy, e_id;
    logic [3:0] e_pc, e_dc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and return at the falling edge.
  task automatic cyc(input logic sr, input logic pr, input logic dr, input logic [3:0] dk);
    @(posedge clk);
    #1;
    start_round = sr;
    player_req  = pr;
    dealer_req  = dr;
    deck_card   = dk;
    @(negedge clk);
  endtask

  task automatic add(input logic sr, pr, dr, input logic [3:0] dk,
                     input logic dreq, cv, input logic [3:0] card,
                     input logic td, pa, da, bsy, id, input logic [3:0] pc, dc);
    vec_t v;
    v.sr = sr; v.pr = pr; v.dr = dr; v.dk = dk;
    v.e_dreq = dreq; v.e_cv = cv; v.e_card = card; v.e_td = td;
    v.e_pa = pa; v.e_da = da; v.e_busy = bsy; v.e_id = id;
    v.e_pc = pc; v.e_dc = dc;
    vecs.push_back(v);
  endtask

  // Draw/deliver pairs with a legal card; checks the strobe and destination of each.
  task automatic deal_cards(input int n, input int first_idx);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 4'd4);
      chk("deal_draw_req", deck_req, 1);
      cyc(0, 0, 0, 4'd0);
      chk("deal_valid", card_valid, 1);
      chk("deal_dest", card_to_dealer, (first_idx + i) % 2);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_deck_req", deck_req, 0);
    chk("rst_card_out", card_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_player_count", player_count, 0);
    chk("rst_dealer_count", dealer_count, 0);
    chk("rst_shoe_empty", shoe_empty, 0);

    // IDLE ignores hit requests
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("idle_deck_req", deck_req, 0);
    chk("idle_busy", busy, 0);
    chk("idle_player_ack", player_ack, 0);

`ifdef CARD_LIMIT_EN
    // Opening deal plus two hits empties a 6-card shoe
    cyc(1, 0, 0, 0);
    deal_cards(4, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 4'd2);
    cyc(0, 1, 0, 0);
    chk("lim_player_ack", player_ack, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 4'd2);
    cyc(0, 0, 1, 0);
    chk("lim_dealer_ack", dealer_ack, 1);
    cyc(0, 0, 0, 0);
    chk("lim_shoe_empty", shoe_empty, 1);
    chk("lim_pc", player_count, 3);
    chk("lim_dc", dealer_count, 3);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 4'd2);
      chk("lim_no_deck_req", deck_req, 0);
      chk("lim_no_ack", player_ack, 0);
      chk("lim_no_valid", card_valid, 0);
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 4'd2);
    chk("lim_restart_keeps_empty", shoe_empty, 1);
    chk("lim_restart_no_req", deck_req, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("lim_reset_clears", shoe_empty, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 4'd2);
    chk("lim_reset_draw", deck_req, 1);
`else
    // sr pr dr dk | dreq cv card td pa da busy id pc dc
    add(1,0,0, 0,  0,0, 0,0,0,0,0,0, 0,0);
    add(0,0,0, 3,  1,0, 0,0,0,0,1,0, 0,0);
    add(0,0,0, 0,  0,1, 3,0,0,0,1,0, 0,0);
    add(0,0,0, 7,  1,0, 3,0,0,0,1,0, 1,0);
    add(0,0,0, 0,  0,1, 7,1,0,0,1,0, 1,0);
    add(0,0,0,10,  1,0, 7,1,0,0,1,0, 1,1);
    add(0,0,0, 0,  0,1,10,0,0,0,1,0, 1,1);
    add(0,0,0, 2,  1,0,10,0,0,0,1,0, 2,1);
    add(0,0,0, 0,  0,1, 2,1,0,0,1,0, 2,1);
    add(0,1,1, 0,  0,0, 2,1,0,0,0,1, 2,2);
    add(0,1,1, 6,  1,0, 2,1,0,0,1,1, 2,2);
    add(0,1,1, 0,  0,1, 6,0,1,0,1,1, 2,2);
    add(0,0,1, 0,  0,0, 6,0,0,0,0,1, 3,2);
    add(0,0,1, 9,  1,0, 6,0,0,0,1,1, 3,2);
    add(0,0,1, 0,  0,1, 9,1,0,1,1,1, 3,2);
    add(0,0,0, 0,  0,0, 9,1,0,0,0,1, 3,3);
    add(1,0,0, 0,  0,0, 9,1,0,0,0,1, 3,3);
    add(0,0,0, 0,  1,0, 9,1,0,0,1,0, 0,0);
    add(0,0,0,14,  1,0, 9,1,0,0,1,0, 0,0);
    add(0,0,0, 5,  1,0, 9,1,0,0,1,0, 0,0);
    add(0,0,0, 0,  0,1, 5,0,0,0,1,0, 0,0);
    add(0,0,0, 4,  1,0, 5,0,0,0,1,0, 1,0);
    add(0,0,0, 0,  0,1, 4,1,0,0,1,0, 1,0);
    add(0,0,0, 8,  1,0, 4,1,0,0,1,0, 1,1);
    add(0,0,0, 0,  0,1, 8,0,0,0,1,0, 1,1);
    add(0,0,0, 1,  1,0, 8,0,0,0,1,0, 2,1);
    add(0,0,0, 0,  0,1, 1,1,0,0,1,0, 2,1);
    add(0,0,0, 0,  0,0, 1,1,0,0,0,1, 2,2);

    foreach (vecs[k]) begin
      cyc(vecs[k].sr, vecs[k].pr, vecs[k].dr, vecs[k].dk);
      chk($sformatf("v%0d_deck_req", k), deck_req, vecs[k].e_dreq);
      chk($sformatf("v%0d_card_valid", k), card_valid, vecs[k].e_cv);
      chk($sformatf("v%0d_card_out", k), card_out, vecs[k].e_card);
      chk($sformatf("v%0d_to_dealer", k), card_to_dealer, vecs[k].e_td);
      chk($sformatf("v%0d_player_ack", k), player_ack, vecs[k].e_pa);
      chk($sformatf("v%0d_dealer_ack", k), dealer_ack, vecs[k].e_da);
      chk($sformatf("v%0d_busy", k), busy, vecs[k].e_busy);
      chk($sformatf("v%0d_init_done", k), init_done, vecs[k].e_id);
      chk($sformatf("v%0d_player_count", k), player_count, vecs[k].e_pc);
      chk($sformatf("v%0d_dealer_count", k), dealer_count, vecs[k].e_dc);
      chk($sformatf("v%0d_shoe_empty", k), shoe_empty, 0);
    end

    // start_round during HIT_DRAW abandons the grant
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 4'd6);
    chk("abort_draw_no_ack", player_ack, 0);
    chk("abort_draw_no_valid", card_valid, 0);
    cyc(0, 0, 0, 4'd0);
    chk("abort_draw_pc", player_count, 0);
    chk("abort_draw_dc", dealer_count, 0);
    chk("abort_draw_init_done", init_done, 0);
    chk("abort_draw_card_kept", card_out, 1);
    chk("abort_draw_redeal_req", deck_req, 1);
    cyc(0, 0, 0, 4'd5);
    cyc(0, 0, 0, 4'd0);
    chk("abort_first_valid", card_valid, 1);
    chk("abort_first_card", card_out, 5);
    chk("abort_first_to_player", card_to_dealer, 0);
    deal_cards(3, 1);
    cyc(0, 0, 0, 0);
    chk("abort_redeal_done", init_done, 1);
    chk("abort_redeal_pc", player_count, 2);

    // start_round during HIT_DELIVER suppresses the strobe and ack
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 4'd7);
    cyc(1, 0, 1, 0);
    chk("abort_dlv_no_valid", card_valid, 0);
    chk("abort_dlv_no_ack", dealer_ack, 0);
    cyc(0, 0, 0, 0);
    chk("abort_dlv_dc", dealer_count, 0);
    deal_cards(4, 0);
    cyc(0, 0, 0, 0);
    chk("sat_start_pc", player_count, 2);

    // Player hits 14 times; count saturates at 15
    for (int i = 0; i < 14; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 4'd3);
      cyc(0, 1, 0, 0);
      chk("sat_player_ack", player_ack, 1);
      cyc(0, 0, 0, 0);
      chk("sat_ack_one_cycle", player_ack, 0);
      chk("sat_player_count", player_count, (3 + i > 15) ? 15 : 3 + i);
    end
    chk("sat_dealer_count", dealer_count, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
